// File: rtl/io_pkg.sv
`default_nettype none
// ============================================================================
// Module      : io_pkg
// Description : Shared types and constants for the IO responder slice:
//               poll state encoding and NES button bit positions.
// Revision    : 1.0 - initial release
// ============================================================================
package io_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        LATCH  = 3'd1,
        LOW    = 3'd2,
        HIGH   = 3'd3,
        COMMIT = 3'd4
    } poll_state_t;

    localparam int NUM_BUTTONS = 8;

    // Serial order A first, so A lands in the MSB after eight shifts
    localparam int BTN_A      = 7;
    localparam int BTN_B      = 6;
    localparam int BTN_SELECT = 5;
    localparam int BTN_START  = 4;
    localparam int BTN_UP     = 3;
    localparam int BTN_DOWN   = 2;
    localparam int BTN_LEFT   = 1;
    localparam int BTN_RIGHT  = 0;

endpackage
`default_nettype wire

// File: rtl/io_responder_controller_poller.sv
`default_nettype none
// ============================================================================
// Module      : controller_poller
// Description : Once-per-frame NES controller poll: latch, eight serial bits
//               MSB-first into shadows, then atomic commit to button bytes.
//               Controller 2 capture exists only when IO_CONTROLLER_2_EN is
//               defined; otherwise buttons_2 is tied to 8'h00.
// Revision    : 1.0 - initial release
// ============================================================================
module controller_poller
    import io_pkg::*;
#(
    parameter int CLK_DIV = 6
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic       controller_1_data,
    input  logic       controller_2_data,
    output logic       controller_latch,
    output logic       controller_clk,
    output logic [7:0] buttons_1,
    output logic [7:0] buttons_2
);

    localparam int                CNT_W        = 9;
    localparam logic [CNT_W-1:0]  c_div_last   = CNT_W'(CLK_DIV - 1);
    localparam logic [CNT_W-1:0]  c_latch_last = CNT_W'(2 * CLK_DIV - 1);
    localparam logic [2:0]        c_last_bit   = 3'(NUM_BUTTONS - 1);

    poll_state_t      r_state;
    logic [CNT_W-1:0] r_div;
    logic [2:0]       r_bit;
    logic             r_latch;
    logic             r_clk;
    logic [7:0]       r_shadow_1;
    logic [7:0]       r_buttons_1;
`ifdef IO_CONTROLLER_2_EN
    logic [7:0]       r_shadow_2;
    logic [7:0]       r_buttons_2;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= IDLE;
            r_div       <= '0;
            r_bit       <= '0;
            r_latch     <= 1'b0;
            r_clk       <= 1'b0;
            r_shadow_1  <= 8'h00;
            r_buttons_1 <= 8'h00;
`ifdef IO_CONTROLLER_2_EN
            r_shadow_2  <= 8'h00;
            r_buttons_2 <= 8'h00;
`endif
        end else begin
            case (r_state)
                IDLE: begin
                    if (start) begin
                        r_state <= LATCH;
                        r_latch <= 1'b1;
                        r_div   <= '0;
                    end
                end
                LATCH: begin
                    if (r_div == c_latch_last) begin
                        r_state <= LOW;
                        r_latch <= 1'b0;
                        r_clk   <= 1'b0;
                        r_bit   <= '0;
                        r_div   <= '0;
                    end else begin
                        r_div <= r_div + 1'b1;
                    end
                end
                LOW: begin
                    if (r_div == c_div_last) begin
                        r_div      <= '0;
                        // Buttons are active-low on the wire; store pressed as 1
                        r_shadow_1 <= {r_shadow_1[6:0], ~controller_1_data};
`ifdef IO_CONTROLLER_2_EN
                        r_shadow_2 <= {r_shadow_2[6:0], ~controller_2_data};
`endif
                        if (r_bit == c_last_bit) begin
                            r_state <= COMMIT;
                        end else begin
                            r_state <= HIGH;
                            r_clk   <= 1'b1;
                        end
                    end else begin
                        r_div <= r_div + 1'b1;
                    end
                end
                HIGH: begin
                    if (r_div == c_div_last) begin
                        r_div   <= '0;
                        r_clk   <= 1'b0;
                        r_bit   <= r_bit + 1'b1;
                        r_state <= LOW;
                    end else begin
                        r_div <= r_div + 1'b1;
                    end
                end
                COMMIT: begin
                    r_buttons_1 <= r_shadow_1;
`ifdef IO_CONTROLLER_2_EN
                    r_buttons_2 <= r_shadow_2;
`endif
                    r_state     <= IDLE;
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign controller_latch = r_latch;
    assign controller_clk   = r_clk;
    assign buttons_1        = r_buttons_1;

`ifdef IO_CONTROLLER_2_EN
    assign buttons_2 = r_buttons_2;
`else
    logic w_unused_c2_data;
    assign w_unused_c2_data = controller_2_data;
    assign buttons_2        = 8'h00;
`endif

endmodule
`default_nettype wire

// File: rtl/io_responder.sv
`default_nettype none
// ============================================================================
// Module      : io_responder
// Description : CPU responder for IO window 0x7000-0x7003: vblank IRQ flag,
//               IRQB drive, read mux and controller polling. Second controller
//               is enabled by defining IO_CONTROLLER_2_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module io_responder
    import io_pkg::*;
#(
    parameter int CLK_DIV = 6
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       SELECT_in_vblank,
    input  logic       SELECT_clr_vblank_irq,
    input  logic       SELECT_controller_1,
    input  logic       SELECT_controller_2,
    input  logic       cpu_wr,
    output logic [7:0] cpu_data_out,
    input  logic       in_vblank,
    output logic       vblank_irqb,
    output logic       controller_latch,
    output logic       controller_clk,
    input  logic       controller_1_data,
    input  logic       controller_2_data
);

    logic       r_in_vblank_q;
    logic       r_irq_flag;
    logic       r_irqb;
    logic       w_vblank_rise;
    logic       w_irq_clr;
    logic [7:0] w_buttons_1;
    logic [7:0] w_buttons_2;

    assign w_vblank_rise = in_vblank & ~r_in_vblank_q;
    assign w_irq_clr     = cpu_wr & SELECT_clr_vblank_irq;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_in_vblank_q <= 1'b0;
            r_irq_flag    <= 1'b0;
            r_irqb        <= 1'b1;
        end else begin
            r_in_vblank_q <= in_vblank;
            // A new frame must never be lost to a racing acknowledge
            if (w_vblank_rise) begin
                r_irq_flag <= 1'b1;
            end else if (w_irq_clr) begin
                r_irq_flag <= 1'b0;
            end
            r_irqb <= ~r_irq_flag;
        end
    end

    assign vblank_irqb = r_irqb;

    controller_poller #(
        .CLK_DIV (CLK_DIV)
    ) u_poller (
        .clk               (clk),
        .rst               (rst),
        .start             (w_vblank_rise),
        .controller_1_data (controller_1_data),
        .controller_2_data (controller_2_data),
        .controller_latch  (controller_latch),
        .controller_clk    (controller_clk),
        .buttons_1         (w_buttons_1),
        .buttons_2         (w_buttons_2)
    );

    always_comb begin
        cpu_data_out = 8'h00;
        if (SELECT_in_vblank) begin
            cpu_data_out = {7'b0, r_in_vblank_q};
        end else if (SELECT_clr_vblank_irq) begin
            cpu_data_out = {7'b0, r_irq_flag};
        end else if (SELECT_controller_1) begin
            cpu_data_out = w_buttons_1;
        end else if (SELECT_controller_2) begin
            cpu_data_out = w_buttons_2;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_io_responder.sv
`default_nettype none
// ============================================================================
// Module      : tb_io_responder
// Description : Directed self-checking bench for io_responder (CLK_DIV=2)
//               with a serial NES controller model and a button scoreboard.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_io_responder;

    localparam int CLK_DIV = 2;

    logic       clk = 1'b0;
    logic       rst;
    logic       sel_vb, sel_clr, sel_c1, sel_c2;
    logic       cpu_wr;
    logic [7:0] cpu_data_out;
    logic       in_vblank;
    logic       vblank_irqb;
    logic       controller_latch;
    logic       controller_clk;
    logic       c1_data, c2_data;

    int checks   = 0;
    int failures = 0;

    logic [7:0] pat1 = 8'h00;
    logic [7:0] pat2 = 8'h00;
    logic [7:0] sb_q[$];

    int         mon_latch_cycles = 0;
    int         mon_clk_pulses   = 0;
    int         mon_clk_high     = 0;
    int         mon_overlap      = 0;
    logic       mon_prev_clk     = 1'b0;
    logic [2:0] c_idx            = 3'd0;

    io_responder #(
        .CLK_DIV (CLK_DIV)
    ) dut (
        .clk                   (clk),
        .rst                   (rst),
        .SELECT_in_vblank      (sel_vb),
        .SELECT_clr_vblank_irq (sel_clr),
        .SELECT_controller_1   (sel_c1),
        .SELECT_controller_2   (sel_c2),
        .cpu_wr                (cpu_wr),
        .cpu_data_out          (cpu_data_out),
        .in_vblank             (in_vblank),
        .vblank_irqb           (vblank_irqb),
        .controller_latch      (controller_latch),
        .controller_clk        (controller_clk),
        .controller_1_data     (c1_data),
        .controller_2_data     (c2_data)
    );

    always #5 clk = ~clk;

    // Shift-register controller: latch reloads, rising serial clock advances
    always @(negedge clk) begin
        if (controller_latch) mon_latch_cycles++;
        if (controller_clk) mon_clk_high++;
        if (controller_clk && !mon_prev_clk) mon_clk_pulses++;
        if (controller_latch && controller_clk) mon_overlap++;
        if (controller_latch)
            c_idx = 3'd0;
        else if (controller_clk && !mon_prev_clk && c_idx != 3'd7)
            c_idx = c_idx + 3'd1;
        mon_prev_clk = controller_clk;
    end

    assign c1_data = ~pat1[3'd7 - c_idx];
    assign c2_data = ~pat2[3'd7 - c_idx];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_mon();
        mon_latch_cycles = 0;
        mon_clk_pulses   = 0;
        mon_clk_high     = 0;
        mon_overlap      = 0;
    endtask

    task automatic rd(input int sel, output logic [7:0] d);
        sel_vb  = (sel == 0);
        sel_clr = (sel == 1);
        sel_c1  = (sel == 2);
        sel_c2  = (sel == 3);
        #1;
        d       = cpu_data_out;
        sel_vb  = 1'b0;
        sel_clr = 1'b0;
        sel_c1  = 1'b0;
        sel_c2  = 1'b0;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_rd(input string tag, input int sel, input logic [7:0] exp);
        logic [7:0] d;
        rd(sel, d);
        check(tag, {24'h0, d}, {24'h0, exp});
    endtask

    task automatic check_pop(input string tag);
        logic [7:0] d;
        logic [7:0] exp;
        rd(2, d);
        checks++;
        if (sb_q.size() == 0) begin
            failures++;
            $error("FAIL %s observed=%0h expected=<none queued>", tag, d);
        end else begin
            exp = sb_q.pop_front();
            assert (d === exp) else begin
                failures++;
                $error("FAIL %s observed=%0h expected=%0h", tag, d, exp);
            end
        end
    endtask

    initial begin
        rst       = 1'b1;
        sel_vb    = 1'b0;
        sel_clr   = 1'b0;
        sel_c1    = 1'b0;
        sel_c2    = 1'b0;
        cpu_wr    = 1'b0;
        in_vblank = 1'b0;
        repeat (3) tick();

        check("rst_irqb", {31'h0, vblank_irqb}, 32'h1);
        check("rst_latch", {31'h0, controller_latch}, 32'h0);
        check("rst_clk", {31'h0, controller_clk}, 32'h0);
        check_rd("rst_rd_7000", 0, 8'h00);
        check_rd("rst_rd_7001", 1, 8'h00);
        check_rd("rst_rd_7002", 2, 8'h00);
        check_rd("rst_rd_7003", 3, 8'h00);
        rst = 1'b0;
        tick();

        // Poll 1: A + Right pressed, plus IRQ set/clear timing
        pat1 = 8'h81;
        pat2 = 8'h42;
        clear_mon();
        sb_q.push_back(8'h81);
        in_vblank = 1'b1;
        tick();
        check("irqb_one_cycle_after_edge", {31'h0, vblank_irqb}, 32'h1);
        check_rd("rd_7001_flag", 1, 8'h01);
        check_rd("rd_7000_vblank", 0, 8'h01);
        tick();
        check("irqb_two_cycles_after_edge", {31'h0, vblank_irqb}, 32'h0);
        cpu_wr  = 1'b1;
        sel_clr = 1'b1;
        tick();
        cpu_wr  = 1'b0;
        sel_clr = 1'b0;
        tick();
        check("irqb_after_clear", {31'h0, vblank_irqb}, 32'h1);
        check_rd("rd_7001_cleared", 1, 8'h00);
        repeat (36) tick();
        check_pop("poll1_buttons_1");
        check("poll1_latch_cycles", mon_latch_cycles, 32'd4);
        check("poll1_clk_pulses", mon_clk_pulses, 32'd7);
        check("poll1_clk_high_cycles", mon_clk_high, 32'd14);
        check("poll1_overlap", mon_overlap, 32'd0);

        // Poll 2: set wins over clear, mid-poll read sees old byte, extra rise ignored
        in_vblank = 1'b0;
        tick();
        pat1 = 8'hFF;
        clear_mon();
        sb_q.push_back(8'hFF);
        in_vblank = 1'b1;
        cpu_wr    = 1'b1;
        sel_clr   = 1'b1;
        tick();
        cpu_wr  = 1'b0;
        sel_clr = 1'b0;
        tick();
        check("set_wins_irqb", {31'h0, vblank_irqb}, 32'h0);
        repeat (8) tick();
        in_vblank = 1'b0;
        tick();
        in_vblank = 1'b1;
        tick();
        repeat (8) tick();
        check_rd("mid_poll_old_byte", 2, 8'h81);
        repeat (19) tick();
        check_pop("poll2_buttons_1");
        check_rd("poll2_rd_7003", 3, 8'h00);
        check("poll2_latch_cycles", mon_latch_cycles, 32'd4);
        check("poll2_clk_pulses", mon_clk_pulses, 32'd7);

        // Reset during HIGH of bit 3 aborts the poll
        in_vblank = 1'b0;
        tick();
        pat1 = 8'h5A;
        in_vblank = 1'b1;
        tick();
        repeat (18) tick();
        check("high_bit3_clk", {31'h0, controller_clk}, 32'h1);
        rst       = 1'b1;
        in_vblank = 1'b0;
        tick();
        check("midrst_latch", {31'h0, controller_latch}, 32'h0);
        check("midrst_clk", {31'h0, controller_clk}, 32'h0);
        check("midrst_irqb", {31'h0, vblank_irqb}, 32'h1);
        check_rd("midrst_rd_7002", 2, 8'h00);
        rst = 1'b0;
        tick();
        pat1 = 8'h3C;
        clear_mon();
        sb_q.push_back(8'h3C);
        in_vblank = 1'b1;
        tick();
        repeat (39) tick();
        check_pop("poll3_buttons_1");
        check_rd("poll3_rd_7003", 3, 8'h00);
        check("poll3_latch_cycles", mon_latch_cycles, 32'd4);
        check("poll3_clk_pulses", mon_clk_pulses, 32'd7);
        check("poll3_clk_high_cycles", mon_clk_high, 32'd14);
        check("poll3_overlap", mon_overlap, 32'd0);
        check("scoreboard_empty", sb_q.size(), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/io_responder.md
Name: io_responder

Overview:
- CPU-side responder for the IO window 0x7000–0x7003.
- Consumes the decoder's SELECT_in_vblank, SELECT_clr_vblank_irq, SELECT_controller_1 and SELECT_controller_2 strobes.
- Owns the vblank IRQ flag and drives the 6502 IRQB line.
- Autonomously polls two NES-style serial controllers once per frame and presents latched button bytes for CPU reads.

Parameters:
- CLK_DIV, 6: half-period of the controller serial clock, in clk cycles. Legal range 1..255. Latch pulse width is 2*CLK_DIV.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous, active-high reset
- SELECT_in_vblank  in  1  decoder select, address 0x7000
- SELECT_clr_vblank_irq  in  1  decoder select, address 0x7001
- SELECT_controller_1  in  1  decoder select, address 0x7002
- SELECT_controller_2  in  1  decoder select, address 0x7003
- cpu_wr  in  1  CPU write strobe, one cycle per bus write
- cpu_data_out  out  8  read data
- in_vblank  in  1  level from video timing, synchronous to clk
- vblank_irqb  out  1  active-low IRQ to CPU
- controller_latch  out  1  latch to both controllers
- controller_clk  out  1  serial clock to both controllers
- controller_1_data  in  1  serial data, active-low buttons
- controller_2_data  in  1  serial data, active-low buttons

Behaviour:
- Clock and reset: one clock; reset is synchronous and active-high (clk, rst).
- Reset values:
  - vblank_irqb=1, controller_latch=0, controller_clk=0.
  - Button registers 8'h00; FSM in IDLE; in_vblank edge register 0.
  - cpu_data_out=8'h00.
- Vblank edge detect: vblank_rise = in_vblank & ~in_vblank_q. in_vblank_q is registered.
- IRQ flag:
  - Set on vblank_rise.
  - Cleared on cpu_wr & SELECT_clr_vblank_irq. The write data value is ignored.
  - If set and clear occur in the same cycle, set wins.
  - vblank_irqb = ~flag, registered; it changes the cycle after the event.
  - Reads of 0x7001 do not clear the flag.
- Read mux (combinational from registered state, zero latency, reads have no side effects):
  - 0x7000: {7'b0, in_vblank_q}
  - 0x7001: {7'b0, irq_flag}
  - 0x7002: buttons_1
  - 0x7003: buttons_2
  - No select asserted: 8'h00. More than one select asserted: priority in_vblank > clr > c1 > c2.
- Writes to 0x7000, 0x7002 and 0x7003 are ignored.
- Poll FSM states: IDLE, LATCH, LOW, HIGH, COMMIT. A divider counter counts 0..(n-1); a bit counter counts 0..7.
  - IDLE: on vblank_rise go to LATCH. controller_latch=1 for 2*CLK_DIV cycles.
  - LATCH -> LOW, with bit=0, latch=0, clk=0.
  - LOW: hold CLK_DIV cycles. On the last cycle, sample both data inputs, invert them, and shift into the shadows MSB-first. The first sampled bit (A) ends at bit 7; the eighth (Right) at bit 0.
    - If bit==7, go to COMMIT.
    - Otherwise go to HIGH.
  - HIGH: controller_clk=1 for CLK_DIV cycles, then bit++ and go to LOW.
  - COMMIT: one cycle. Copy shadows to buttons_1/buttons_2, then go to IDLE.
  - A full poll lasts 2*CLK_DIV + 8*CLK_DIV + 7*CLK_DIV + 1 cycles.
- Boundary cases:
  - vblank_rise while not IDLE is ignored for polling. The IRQ is still set.
  - Button registers update only in COMMIT, so a CPU read never sees a partial byte.
  - controller_latch and controller_clk are registered outputs and are never high simultaneously.
  - rst mid-poll aborts to IDLE. Outputs and registers return to reset values; shadows are discarded.

Optional Feature:
- Macro: IO_CONTROLLER_2_EN.
- Defined: controller 2 is sampled and committed as above.
- Undefined:
  - controller_2_data is ignored.
  - buttons_2 is held at 8'h00, so a read of 0x7003 returns 8'h00.
  - No shadow_2 flops are instantiated.
  - The port remains present.

Decomposition:
- Package io_pkg holds:
  - typedef enum logic [2:0] poll_state_t {IDLE, LATCH, LOW, HIGH, COMMIT}
  - localparam NUM_BUTTONS = 8
  - Button bit-index constants BTN_A=7 … BTN_RIGHT=0.
- One natural sub-module, controller_poller: the FSM, divider, shadows and commit. It outputs buttons_1/2 and the latch/clk pins.
- io_responder keeps the IRQ flag, the edge detect and the read mux.

Test Plan:
- Reset with CLK_DIV=2 -> vblank_irqb=1, latch=0, clk=0; reads of 0x7000–0x7003 return 8'h00.
- in_vblank 0->1 -> vblank_irqb low 2 cycles after the edge (edge register + IRQ register); read 0x7001 = 8'h01; cpu_wr with SELECT_clr_vblank_irq -> irqb=1 next cycle.
- Set and clear in the same cycle: cpu_wr+SELECT_clr_vblank_irq coincident with vblank_rise -> irqb stays 0.
- Controller model with A and Right pressed (serial 0,1,1,1,1,1,1,0) -> latch high exactly 4 cycles; 7 clk pulses of 2 cycles each; after COMMIT, 0x7002 reads 8'h81.
- Read 0x7002 mid-poll after a previous 8'h81 while the new pattern is 8'hFF -> returns 8'h81 until COMMIT, then 8'hFF.
- Assert rst during the HIGH state of bit 3 -> next cycle latch=0, clk=0, buttons=00. A following vblank_rise starts a clean full poll. Without IO_CONTROLLER_2_EN, 0x7003 always reads 8'h00.
